// File: rtl/pd_pulse_gen.sv
// Programmable pulse-train generator: rising edges every per_l enable ticks,
// HIGH for wid_l ticks, for cnt_l pulses (0 = run until stop).
module pd_pulse_gen #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enb,
  input  logic         start,
  input  logic         stop,
  input  logic [W-1:0] period,
  input  logic [W-1:0] width,
  input  logic [W-1:0] count,
  output logic         pulse,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] ph_q, ph_d;
  logic [W-1:0] left_q, left_d;
  logic [W-1:0] per_q, per_d;
  logic [W-1:0] wid_q, wid_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q, done_d;
  logic [W-1:0] per_clamp_s;
  logic [W-1:0] wid_clamp_s;

  // Clamp so that the train always has at least one HIGH and one LOW tick.
  always_comb begin
    per_clamp_s = (period < W'(2)) ? W'(2) : period;
    wid_clamp_s = (width == {W{1'b0}}) ? W'(1) : width;
    if (wid_clamp_s >= per_clamp_s) begin
      wid_clamp_s = per_clamp_s - W'(1);
    end else begin
      wid_clamp_s = wid_clamp_s;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    left_d  = left_q;
    per_d   = per_q;
    wid_d   = wid_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      ph_d    = {W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          // The done cycle is IDLE too; a start there must wait one clock.
          if (start && !done_q) begin
            state_d = HIGH;
            per_d   = per_clamp_s;
            wid_d   = wid_clamp_s;
            cnt_d   = count;
            left_d  = count;
            ph_d    = {W{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end
        HIGH: begin
          if (enb) begin
            ph_d = ph_q + W'(1);
            if (ph_q == wid_q - W'(1)) begin
              state_d = LOW;
            end else begin
              state_d = HIGH;
            end
          end else begin
            state_d = HIGH;
          end
        end
        LOW: begin
          if (enb) begin
            if (ph_q == per_q - W'(1)) begin
              ph_d = {W{1'b0}};
              if ((cnt_q != {W{1'b0}}) && (left_q == W'(1))) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = HIGH;
                if (cnt_q != {W{1'b0}}) begin
                  left_d = left_q - W'(1);
                end else begin
                  left_d = left_q;
                end
              end
            end else begin
              ph_d    = ph_q + W'(1);
              state_d = LOW;
            end
          end else begin
            state_d = LOW;
          end
        end
        default: begin
          state_d = IDLE;
          ph_d    = {W{1'b0}};
        end
      endcase
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q    <= {W{1'b0}};
      left_q  <= {W{1'b0}};
      per_q   <= {W{1'b0}};
      wid_q   <= {W{1'b0}};
      cnt_q   <= {W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      left_q  <= left_d;
      per_q   <= per_d;
      wid_q   <= wid_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign pulse = (state_q == HIGH);
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

endmodule

// File: tb/tb_pd_pulse_gen.sv
// Directed bench for pd_pulse_gen; checks {pulse,busy,done} every clock
// against hand-derived sequences.
module tb_pd_pulse_gen;

  logic       clk = 1'b0;
  logic       rst, enb, start, stop;
  logic [7:0] period, width, count;
  logic       pulse, busy, done;
  int         checks = 0;
  int         errors = 0;

  pd_pulse_gen #(.W(8)) dut (
    .clk(clk), .rst(rst), .enb(enb), .start(start), .stop(stop),
    .period(period), .width(width), .count(count),
    .pulse(pulse), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] exp);
    checks++;
    assert ({pulse, busy, done} === exp) else begin
      errors++;
      $error("FAIL %s observed pbd=%b expected pbd=%b", tag, {pulse, busy, done}, exp);
    end
  endtask

  task automatic launch(input logic [7:0] p, input logic [7:0] w, input logic [7:0] c);
    period = p; width = w; count = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enb = 1'b1; start = 1'b0; stop = 1'b0;
    period = 8'd0; width = 8'd0; count = 8'd0;
    tick(); tick();
    chk("reset", 3'b000);
    rst = 1'b0;
    tick();
    chk("idle", 3'b000);

    // 1: period 5, width 2, count 3 -> 11000 x3 then done strobe
    launch(8'd5, 8'd2, 8'd3);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("t1_i%0d", i), {((i % 5) < 2), 1'b1, 1'b0});
      tick();
    end
    chk("t1_done", 3'b001);
    tick();
    chk("t1_after", 3'b000);

    // 2: enb 1-in-4, period 3, width 1, count 2 -> HIGH 4, LOW 8 clocks
    launch(8'd3, 8'd1, 8'd2);
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("t2_i%0d", i), {((i % 12) < 4), 1'b1, 1'b0});
      enb = ((i % 4) == 3);
      tick();
    end
    enb = 1'b0;
    chk("t2_done", 3'b001);
    tick();
    chk("t2_after", 3'b000);
    enb = 1'b1;

    // 3a: period 0, width 0 clamp to 2/1
    launch(8'd0, 8'd0, 8'd1);
    chk("t3a_hi", 3'b110); tick();
    chk("t3a_lo", 3'b010); tick();
    chk("t3a_done", 3'b001); tick();
    chk("t3a_after", 3'b000);

    // 3b: width 9 > period 4 clamps to width 3
    launch(8'd4, 8'd9, 8'd1);
    chk("t3b_hi0", 3'b110); tick();
    chk("t3b_hi1", 3'b110); tick();
    chk("t3b_hi2", 3'b110); tick();
    chk("t3b_lo", 3'b010); tick();
    chk("t3b_done", 3'b001); tick();
    chk("t3b_after", 3'b000);

    // 4: continuous train, stop after 10 pulses
    launch(8'd4, 8'd2, 8'd0);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("t4_i%0d", i), {((i % 4) < 2), 1'b1, 1'b0});
      tick();
    end
    chk("t4_pulse11", 3'b110);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_stopped", 3'b000);
    tick();
    chk("t4_stopped2", 3'b000);

    // 5: restart while busy is ignored; start on done cycle waits a clock
    launch(8'd5, 8'd2, 8'd2);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t5_i%0d", i), {((i % 5) < 2), 1'b1, 1'b0});
      if (i == 2) begin
        period = 8'd7; width = 8'd3; count = 8'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("t5_done", 3'b001);
    period = 8'd3; width = 8'd1; count = 8'd1; start = 1'b1;
    tick();
    chk("t5_start_on_done", 3'b000);
    tick();
    start = 1'b0;
    chk("t5_accept_hi", 3'b110); tick();
    chk("t5_lo0", 3'b010); tick();
    chk("t5_lo1", 3'b010); tick();
    chk("t5_done2", 3'b001); tick();
    start = 1'b1; stop = 1'b1;
    tick();
    chk("t5_stop_start", 3'b000);
    start = 1'b0; stop = 1'b0;
    tick();
    chk("t5_idle", 3'b000);

    // 6: reset mid-HIGH, then a fresh single pulse
    launch(8'd5, 8'd2, 8'd3);
    chk("t6_hi", 3'b110);
    rst = 1'b1;
    tick();
    chk("t6_rst", 3'b000);
    rst = 1'b0;
    tick();
    chk("t6_idle", 3'b000);
    launch(8'd5, 8'd2, 8'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t6_i%0d", i), {(i < 2), 1'b1, 1'b0});
      tick();
    end
    chk("t6_done", 3'b001);
    tick();
    chk("t6_after", 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
